alu_ctrl_mc: RTL and testbench
==============================

# alu_ctrl_mc

Parametrised ALU control unit for the EX stage of the pipelined CPU, replacing the purely combinational funct/ALUOp decoder. It decodes `funct_i`/`ALUOp_i` into the ALU operation code for all ALUOp modes. It also sequences multi-cycle operations (MUL, optionally DIV): it pulses a start to the iterative datapath, holds a pipeline stall for a fixed latency and signals completion. The hazard unit consumes `stall_o`; the iterative multiplier/divider consumes `mc_start_o` and `ALUCtrl_o`.

## Interface
- `CTRL_W`, default 3: width of `ALUCtrl_o`; must be ≥3, upper bits zero.
- `MUL_LAT`, default 4: total cycles a MUL holds the pipeline; must be ≥1.
- `DIV_LAT`, default 16: total cycles a DIV holds the pipeline; must be ≥1; used only with `ALU_CTRL_DIV_EN`.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset; synchronous, active-low.
- `valid_i` in 1: instruction in EX is valid.
- `flush_i` in 1: abort any multi-cycle operation in flight.
- `funct_i` in 6: R-type function field.
- `ALUOp_i` in 2: main-control ALU mode.
- `ALUCtrl_o` out CTRL_W: ALU operation code.
- `stall_o` out 1: freeze IF/ID/EX.
- `busy_o` out 1: sequencer not in IDLE.
- `mc_start_o` out 1: one-cycle start pulse to the iterative unit.
- `mc_done_o` out 1: one-cycle result-valid pulse.

## Operation
- Decode, low 3 bits of the code:
  - ALUOp 00 → 010 (add, lw/sw/addi).
  - ALUOp 01 → 110 (sub, beq).
  - ALUOp 10 → 001 (or, ori).
  - ALUOp 11 by funct: 100000 → 010 add; 100010 → 110 sub; 100100 → 000 and; 100101 → 001 or; 011000 → 100 mul; 011010 → 101 div (macro only); any other funct → 010.
- Multi-cycle op (`is_mc`): ALUOp 11 with MUL funct, or DIV funct when enabled.
- FSM states IDLE, RUN, DONE. 3-bit op register `op_q` and down-counter `cnt_q` of width $clog2(max(MUL_LAT,DIV_LAT)+1).
- IDLE:
  - `ALUCtrl_o` = combinational decode of the inputs.
  - If `valid_i && is_mc && !flush_i`: `mc_start_o`=1, `stall_o`=1, `op_q` ← decode, `cnt_q` ← LAT-1.
  - Next state: DONE if LAT=1, else RUN.
- RUN:
  - `ALUCtrl_o`=`op_q`, `stall_o`=1, `busy_o`=1; inputs ignored except `flush_i`.
  - `cnt_q` decrements each cycle. When `cnt_q`=1, next state is DONE.
- DONE:
  - `ALUCtrl_o`=`op_q`, `mc_done_o`=1, `stall_o`=0, `busy_o`=1; `valid_i` ignored.
  - Next state is IDLE.
- Flush:
  - `flush_i` in RUN or DONE → IDLE next cycle, with no `mc_done_o` afterwards. Flush wins over counter expiry in the same cycle.
  - `flush_i` in IDLE suppresses start.
- Back-to-back MUL: the second MUL starts in the first IDLE cycle after DONE.

## Timing
- Reset (`rst_i`=0 at a rising edge) → state IDLE, `cnt_q`=0, `op_q`=010.
- While `rst_i`=0: `stall_o`, `busy_o`, `mc_start_o`, `mc_done_o` = 0, and `ALUCtrl_o` = 010.
- Reset mid-RUN aborts the operation with no `mc_done_o`.
- Single-cycle ops: zero latency, purely combinational, `stall_o`=0.
- Multi-cycle op with latency LAT, start at cycle t:
  - `stall_o` high in cycles t … t+LAT-1 (exactly LAT cycles).
  - `mc_done_o` high in cycle t+LAT, with `stall_o` low.
  - `busy_o` high in t+1 … t+LAT.
- `mc_start_o` is never high in two consecutive cycles.

## Configuration
- `ALU_CTRL_DIV_EN` defined:
  - funct 011010 under ALUOp 11 decodes to 101.
  - It is multi-cycle with latency DIV_LAT, and `op_q` latches the LAT selection.
- Not defined:
  - funct 011010 decodes to the default 010 and is single-cycle.
  - DIV_LAT is unused, and no DIV logic is synthesised.

## Test plan
- ALUOp 11 with funct 100000/100010/100100/100101/111111, and ALUOp 00/01/10, `valid_i`=1 → `ALUCtrl_o` 010/110/000/001/010/010/110/001, `stall_o`=0 throughout.
- MUL_LAT=4, MUL issued at cycle 10 → `mc_start_o` high at cycle 10 only, `stall_o` high at cycles 10–13, `mc_done_o` high at 14, `ALUCtrl_o`=100 at cycles 10–14 even if `funct_i` changes at cycle 11.
- MUL_LAT=1 → start and stall at cycle t, `mc_done_o` at t+1, no RUN state visited.
- MUL at cycle 0 (MUL_LAT=4), `flush_i` at cycle 3 → state IDLE at cycle 4, `stall_o`=0, `mc_done_o` never asserted.
- `rst_i`=0 at cycle 2 of a MUL → all flags 0 and `ALUCtrl_o`=010 while low; after release, a new MUL gives the full 4-cycle stall.
- With `ALU_CTRL_DIV_EN`, DIV_LAT=16, funct 011010 → `ALUCtrl_o`=101, 16 stall cycles, then `mc_done_o`. Without the macro → `ALUCtrl_o`=010, no stall.

Source files
------------

// File: rtl/alu_ctrl_mc.sv
// EX-stage ALU control: funct/ALUOp decode plus a start/stall/done sequencer for iterative MUL (and DIV).
// Optional DIV support is enabled by defining ALU_CTRL_DIV_EN.
module alu_ctrl_mc #(
  parameter int unsigned CTRL_W  = 3,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [5:0]        funct_i,
  input  logic [1:0]        ALUOp_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic              mc_start_o,
  output logic              mc_done_o
);

`ifdef ALU_CTRL_DIV_EN
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
`else
  localparam int unsigned MAX_LAT = MUL_LAT;
`endif
  localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b100;
`ifdef ALU_CTRL_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b101;
`endif

  // Elaboration-time parameter sanity checks
  if (CTRL_W < 3) begin : g_bad_ctrl_w
    $error("alu_ctrl_mc: CTRL_W must be >= 3");
  end
  if (MUL_LAT < 1) begin : g_bad_mul_lat
    $error("alu_ctrl_mc: MUL_LAT must be >= 1");
  end
  if (DIV_LAT < 1) begin : g_bad_div_lat
    $error("alu_ctrl_mc: DIV_LAT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       dec_op;
  logic             is_mc;
  logic [CNT_W-1:0] lat_m1;
  logic [2:0]       alu_op;

  // funct/ALUOp decode and multi-cycle classification
  always_comb begin
    dec_op = OP_ADD;
    is_mc  = 1'b0;
    case (ALUOp_i)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: dec_op = OP_OR;
      default: begin
        case (funct_i)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b011000: begin
            dec_op = OP_MUL;
            is_mc  = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          6'b011010: begin
            dec_op = OP_DIV;
            is_mc  = 1'b1;
          end
`endif
          default: dec_op = OP_ADD;
        endcase
      end
    endcase
  end

  // Counter preload is latency minus one; the start cycle itself is the first stall cycle
  always_comb begin
    lat_m1 = CNT_W'(MUL_LAT - 1);
`ifdef ALU_CTRL_DIV_EN
    if (dec_op == OP_DIV) lat_m1 = CNT_W'(DIV_LAT - 1);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and outputs; IDLE passes the decode straight through so single-cycle ops see no latency
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    alu_op     = dec_op;
    stall_o    = 1'b0;
    busy_o     = 1'b0;
    mc_start_o = 1'b0;
    mc_done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && is_mc && !flush_i) begin
          mc_start_o = 1'b1;
          stall_o    = 1'b1;
          op_d       = dec_op;
          cnt_d      = lat_m1;
          state_d    = (lat_m1 == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        alu_op  = op_q;
        stall_o = 1'b1;
        busy_o  = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        alu_op    = op_q;
        mc_done_o = 1'b1;
        busy_o    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Hold everything quiet while reset is asserted
    if (!rst_i) begin
      alu_op     = OP_ADD;
      stall_o    = 1'b0;
      busy_o     = 1'b0;
      mc_start_o = 1'b0;
      mc_done_o  = 1'b0;
    end
  end

  assign ALUCtrl_o = CTRL_W'(alu_op);

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: decode table, MUL sequencing, flush, reset and LAT=1 variant.
module tb_alu_ctrl_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, flush;
  logic [5:0] funct;
  logic [1:0] aluop;
  logic [2:0] alu_ctrl;
  logic       stall, busy, start, done;

  logic       valid1;
  logic [5:0] funct1;
  logic [1:0] aluop1;
  logic [3:0] alu1;
  logic       stall1, busy1, start1, done1;

  alu_ctrl_mc #(.CTRL_W(3), .MUL_LAT(4), .DIV_LAT(16)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
    .funct_i(funct), .ALUOp_i(aluop), .ALUCtrl_o(alu_ctrl),
    .stall_o(stall), .busy_o(busy), .mc_start_o(start), .mc_done_o(done)
  );

  alu_ctrl_mc #(.CTRL_W(4), .MUL_LAT(1), .DIV_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid1), .flush_i(1'b0),
    .funct_i(funct1), .ALUOp_i(aluop1), .ALUCtrl_o(alu1),
    .stall_o(stall1), .busy_o(busy1), .mc_start_o(start1), .mc_done_o(done1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] op;
    int         due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion monitor: each mc_done_o must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (start) check("start_consec", 32'(prev_start), 32'd0);
    prev_start = start;
    if (done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_op", 32'(alu_ctrl), 32'(mon_e.op));
        check("done_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_mc(input logic [5:0] f, input int lat, input logic [2:0] op);
    valid = 1'b1; aluop = 2'b11; funct = f; flush = 1'b0;
    @(negedge clk);
    check("iss_start", 32'(start), 32'd1);
    check("iss_stall", 32'(stall), 32'd1);
    check("iss_busy", 32'(busy), 32'd0);
    check("iss_op", 32'(alu_ctrl), 32'(op));
    sb.push_back('{op: op, due: cyc + lat});
    for (int k = 1; k < lat; k++) begin
      step();
      funct = 6'b100000;
      @(negedge clk);
      check("run_stall", 32'(stall), 32'd1);
      check("run_busy", 32'(busy), 32'd1);
      check("run_start", 32'(start), 32'd0);
      check("run_op", 32'(alu_ctrl), 32'(op));
    end
    step();
    valid = 1'b0; funct = 6'b100000;
    @(negedge clk);
    check("done_flag", 32'(done), 32'd1);
    check("done_stall", 32'(stall), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    step();
  endtask

  logic [1:0] t_aluop [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10};
  logic [5:0] t_funct [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111,
                              6'b011000, 6'b011000, 6'b011000};
  logic [2:0] t_exp   [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010, 3'b010, 3'b110, 3'b001};

  initial begin
    rst = 1'b0; valid = 1'b1; flush = 1'b0; aluop = 2'b11; funct = 6'b011000;
    valid1 = 1'b1; aluop1 = 2'b11; funct1 = 6'b011000;
    step(); step();
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alu", 32'(alu_ctrl), 32'd2);
    check("rst_alu1", 32'(alu1), 32'd2);
    check("rst_start1", 32'(start1), 32'd0);
    step();
    rst = 1'b1; valid = 1'b0; valid1 = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    step();

    // Single-cycle decode table
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; aluop = t_aluop[i]; funct = t_funct[i];
      @(negedge clk);
      check("dec_op", 32'(alu_ctrl), 32'(t_exp[i]));
      check("dec_stall", 32'(stall), 32'd0);
      step();
    end

`ifdef ALU_CTRL_DIV_EN
    issue_mc(6'b011010, 16, 3'b101);
`else
    valid = 1'b1; aluop = 2'b11; funct = 6'b011010;
    @(negedge clk);
    check("div_off_op", 32'(alu_ctrl), 32'd2);
    check("div_off_stall", 32'(stall), 32'd0);
    check("div_off_start", 32'(start), 32'd0);
    step();
`endif

    // MUL, then back-to-back MUL
    issue_mc(6'b011000, 4, 3'b100);
    issue_mc(6'b011000, 4, 3'b100);

    // Flush in IDLE suppresses start
    valid = 1'b1; aluop = 2'b11; funct = 6'b011000; flush = 1'b1;
    @(negedge clk);
    check("flidle_start", 32'(start), 32'd0);
    check("flidle_stall", 32'(stall), 32'd0);
    step();
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("flidle_busy", 32'(busy), 32'd0);
    step();

    // Flush in RUN at the counter-expiry cycle
    valid = 1'b1; funct = 6'b011000;
    @(negedge clk);
    check("flrun_start", 32'(start), 32'd1);
    step(); valid = 1'b0;
    step();
    step(); flush = 1'b1;
    @(negedge clk);
    check("flrun_stall3", 32'(stall), 32'd1);
    step(); flush = 1'b0;
    @(negedge clk);
    check("flrun_busy4", 32'(busy), 32'd0);
    check("flrun_stall4", 32'(stall), 32'd0);
    check("flrun_done4", 32'(done), 32'd0);
    step();
    @(negedge clk);
    check("flrun_done5", 32'(done), 32'd0);
    step();

    // Reset in the middle of a MUL
    valid = 1'b1; funct = 6'b011000;
    @(negedge clk);
    check("rstrun_start", 32'(start), 32'd1);
    step(); valid = 1'b0;
    step(); rst = 1'b0;
    @(negedge clk);
    check("rstrun_stall", 32'(stall), 32'd0);
    check("rstrun_busy", 32'(busy), 32'd0);
    check("rstrun_alu", 32'(alu_ctrl), 32'd2);
    step();
    @(negedge clk);
    check("rstrun_stall2", 32'(stall), 32'd0);
    step(); rst = 1'b1;
    @(negedge clk);
    check("rstrel_busy", 32'(busy), 32'd0);
    check("rstrel_done", 32'(done), 32'd0);
    step();
    issue_mc(6'b011000, 4, 3'b100);

    // MUL_LAT=1 instance: no RUN state, done on the following cycle
    valid1 = 1'b1; aluop1 = 2'b11; funct1 = 6'b011000;
    @(negedge clk);
    check("l1_start", 32'(start1), 32'd1);
    check("l1_stall", 32'(stall1), 32'd1);
    check("l1_busy", 32'(busy1), 32'd0);
    check("l1_op", 32'(alu1), 32'h4);
    step(); valid1 = 1'b0; funct1 = 6'b100010;
    @(negedge clk);
    check("l1_done", 32'(done1), 32'd1);
    check("l1_dstall", 32'(stall1), 32'd0);
    check("l1_dbusy", 32'(busy1), 32'd1);
    check("l1_dop", 32'(alu1), 32'h4);
    step();
    @(negedge clk);
    check("l1_idle_busy", 32'(busy1), 32'd0);
    check("l1_idle_done", 32'(done1), 32'd0);
    step(); step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
